// File: rtl/pcma_eq_pkg.sv
// Shared definitions for the PCMA equalizer coefficient/training sequencer:
// FSM state encoding, coefficient and address width helpers, and the
// normalisation period width.
package pcma_eq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRESET = 2'd1,
        ST_LOAD   = 2'd2,
        ST_TEACH  = 2'd3
    } eq_state_t;

    localparam int NORM_W = 10;

    // Full coefficient width: visible bits plus hidden fractional bits.
    function automatic int full_w(input int coe_w, input int inv_w);
        return coe_w + inv_w;
    endfunction

    // Address width needed to index a table of the given depth.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pcma_coe_ram.sv
// Coefficient store: DEPTH x WIDTH simple dual-port RAM, one write port and
// one registered read port (read latency 1). The array itself is not reset;
// only the read data register is, so the equalizer sees 0 after reset.
module pcma_coe_ram
    import pcma_eq_pkg::*;
#(
    parameter int  DEPTH = 17,
    parameter int  WIDTH = 24,
    localparam int AW    = addr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    // Write port; the caller guarantees the address is in range.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read port; holds its value when no read is issued.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/pcma_eq_coe_ctrl.sv
// Coefficient/training sequencer in front of the PCMA complex LMS equalizer.
// Holds EQ_LEN host-written initial coefficients, bursts them into the
// equalizer on a load command, and gates the training window.
// Optional feature: define PCMA_EQ_TRAIN_TIMER_EN to also end training
// automatically after i_train_len symbols (0 = no timeout).
//
// state  | meaning
// IDLE   | waiting for a command; preset > load > teach
// PRESET | o_preset_coe high for one cycle
// LOAD   | RAM read sweep 0..EQ_LEN-1, one o_load_coe pulse per tap
// TEACH  | o_teach_en high, symbols counted, until stop (or timeout)
module pcma_eq_coe_ctrl
    import pcma_eq_pkg::*;
#(
    parameter int  COE_WIDTH     = 16,
    parameter int  INV_COE_WIDTH = 8,
    parameter int  EQ_LEN        = 17,
    parameter int  CNT_W         = 24,
    localparam int FULL_W        = full_w(COE_WIDTH, INV_COE_WIDTH),
    localparam int AW            = addr_w(EQ_LEN)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [FULL_W-1:0] i_wr_data,
    input  logic              i_cmd_preset,
    input  logic              i_cmd_load,
    input  logic              i_cmd_teach,
    input  logic              i_cmd_stop,
    input  logic [NORM_W-1:0] i_norm_per,
    input  logic              i_sym_vld,
    input  logic [CNT_W-1:0]  i_train_len,
    output logic              o_preset_coe,
    output logic              o_load_coe,
    output logic [FULL_W-1:0] o_init_coe,
    output logic              o_teach_en,
    output logic [NORM_W-1:0] o_norm_per,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(EQ_LEN - 1);

    eq_state_t         r_state;
    eq_state_t         w_state_nxt;
    logic [AW-1:0]     r_rd_addr;
    logic              r_rd_act;
    logic              r_rd_vld;
    logic              r_rd_last;
    logic              r_preset;
    logic              r_teach_en;
    logic              r_done;
    logic              r_err;
    logic [NORM_W-1:0] r_norm_per;
    logic [CNT_W-1:0]  r_sym_cnt;
    logic [CNT_W-1:0]  w_sym_cnt_nxt;
    logic              w_cmd_any;
    logic              w_cmd_bad;
    logic              w_wr_bad;
    logic              w_wr_ok;
    logic              w_done_nxt;
    logic              w_timeout;
    logic              w_start_load;
    logic              w_start_teach;
    logic [FULL_W-1:0] w_ram_q;

    assign w_cmd_any     = i_cmd_preset | i_cmd_load | i_cmd_teach;
    // Writes are blocked during LOAD so the burst always sees a stable table.
    assign w_wr_bad      = i_wr_en & ((r_state == ST_LOAD) | (i_wr_addr > LAST_ADDR));
    assign w_wr_ok       = i_wr_en & ~w_wr_bad;
    assign w_start_load  = (r_state == ST_IDLE) & (w_state_nxt == ST_LOAD);
    assign w_start_teach = (r_state == ST_IDLE) & (w_state_nxt == ST_TEACH);

    // Saturating training symbol count, advanced only inside TEACH.
    always_comb begin
        w_sym_cnt_nxt = r_sym_cnt;
        if ((r_state == ST_TEACH) && i_sym_vld && (r_sym_cnt != '1)) begin
            w_sym_cnt_nxt = r_sym_cnt + CNT_W'(1);
        end
    end

`ifdef PCMA_EQ_TRAIN_TIMER_EN
    logic [CNT_W-1:0] r_train_len;

    // Training length is captured once so host changes mid-window are ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_train_len <= '0;
        end else if (w_start_teach) begin
            r_train_len <= i_train_len;
        end
    end

    // Compare the updated count so the window closes on the final symbol edge.
    assign w_timeout = (r_train_len != '0) && (w_sym_cnt_nxt == r_train_len);
`else
    logic w_unused;
    assign w_unused  = ^{i_train_len, r_sym_cnt};
    assign w_timeout = 1'b0;
`endif

    // Next-state decode and command/write rejection.
    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        w_cmd_bad   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_cmd_preset) begin
                    w_state_nxt = ST_PRESET;
                end else if (i_cmd_load) begin
                    w_state_nxt = ST_LOAD;
                end else if (i_cmd_teach) begin
                    w_state_nxt = ST_TEACH;
                end
            end
            ST_PRESET: begin
                w_cmd_bad   = w_cmd_any | i_cmd_stop;
                w_state_nxt = ST_IDLE;
                w_done_nxt  = 1'b1;
            end
            ST_LOAD: begin
                w_cmd_bad = w_cmd_any | i_cmd_stop;
                if (r_rd_vld && r_rd_last) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            ST_TEACH: begin
                w_cmd_bad = w_cmd_any;
                if (i_cmd_stop || w_timeout) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register and registered equalizer/host controls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_preset   <= 1'b0;
            r_teach_en <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_norm_per <= '0;
            r_sym_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_preset   <= (w_state_nxt == ST_PRESET);
            r_teach_en <= (w_state_nxt == ST_TEACH);
            r_done     <= w_done_nxt;
            r_err      <= w_cmd_bad | w_wr_bad;
            if (w_start_teach) begin
                r_norm_per <= i_norm_per;
                r_sym_cnt  <= '0;
            end else begin
                r_sym_cnt  <= w_sym_cnt_nxt;
            end
        end
    end

    // Read sweep: one address per cycle; the RAM output register is the
    // pipeline stage, so r_rd_vld lines up with the data on o_init_coe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_addr <= '0;
            r_rd_act  <= 1'b0;
            r_rd_vld  <= 1'b0;
            r_rd_last <= 1'b0;
        end else begin
            r_rd_vld  <= r_rd_act;
            r_rd_last <= r_rd_act & (r_rd_addr == LAST_ADDR);
            if (w_start_load) begin
                r_rd_addr <= '0;
                r_rd_act  <= 1'b1;
            end else if (r_rd_act) begin
                r_rd_addr <= r_rd_addr + AW'(1);
                if (r_rd_addr == LAST_ADDR) begin
                    r_rd_act <= 1'b0;
                end
            end
        end
    end

    pcma_coe_ram #(
        .DEPTH (EQ_LEN),
        .WIDTH (FULL_W)
    ) u_coe_ram (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_wr_en   (w_wr_ok),
        .i_wr_addr (i_wr_addr),
        .i_wr_data (i_wr_data),
        .i_rd_en   (r_rd_act),
        .i_rd_addr (r_rd_addr),
        .o_rd_data (w_ram_q)
    );

    assign o_preset_coe = r_preset;
    assign o_load_coe   = r_rd_vld;
    assign o_init_coe   = w_ram_q;
    assign o_teach_en   = r_teach_en;
    assign o_norm_per   = r_norm_per;
    assign o_busy       = (r_state != ST_IDLE);
    assign o_done       = r_done;
    assign o_err        = r_err;

endmodule

// File: tb/tb_pcma_eq_coe_ctrl.sv
// Directed bench for pcma_eq_coe_ctrl with a scoreboard queue for burst data.
module tb_pcma_eq_coe_ctrl;
    import pcma_eq_pkg::*;

    localparam int EQ_LEN = 17;
    localparam int FULL_W = 24;
    localparam int AW     = 5;
    localparam int CNT_W  = 24;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              i_wr_en;
    logic [AW-1:0]     i_wr_addr;
    logic [FULL_W-1:0] i_wr_data;
    logic              i_cmd_preset;
    logic              i_cmd_load;
    logic              i_cmd_teach;
    logic              i_cmd_stop;
    logic [NORM_W-1:0] i_norm_per;
    logic              i_sym_vld;
    logic [CNT_W-1:0]  i_train_len;
    logic              o_preset_coe;
    logic              o_load_coe;
    logic [FULL_W-1:0] o_init_coe;
    logic              o_teach_en;
    logic [NORM_W-1:0] o_norm_per;
    logic              o_busy;
    logic              o_done;
    logic              o_err;

    always #5 clk = ~clk;

    pcma_eq_coe_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_wr_en      (i_wr_en),
        .i_wr_addr    (i_wr_addr),
        .i_wr_data    (i_wr_data),
        .i_cmd_preset (i_cmd_preset),
        .i_cmd_load   (i_cmd_load),
        .i_cmd_teach  (i_cmd_teach),
        .i_cmd_stop   (i_cmd_stop),
        .i_norm_per   (i_norm_per),
        .i_sym_vld    (i_sym_vld),
        .i_train_len  (i_train_len),
        .o_preset_coe (o_preset_coe),
        .o_load_coe   (o_load_coe),
        .o_init_coe   (o_init_coe),
        .o_teach_en   (o_teach_en),
        .o_norm_per   (o_norm_per),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err)
    );

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    logic [FULL_W-1:0] exp_q[$];
    logic [FULL_W-1:0] ram_model [EQ_LEN];

    int rel_first;
    int n_pulses;
    int rel_done;
    int n_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [FULL_W-1:0] d);
        i_wr_en   = 1'b1;
        i_wr_addr = AW'(a);
        i_wr_data = d;
        tick();
        i_wr_en   = 1'b0;
        if (a < EQ_LEN) ram_model[a] = d;
    endtask

    // Issues a load command, pushes the expected burst from the model, then
    // pops one entry per observed o_load_coe pulse. Optional injections:
    // a teach command and a write during the burst, and a reset at a pulse.
    task automatic run_load(input int inj_teach_rel, input int inj_wr_rel, input int rst_pulse);
        logic [FULL_W-1:0] exp_v;
        rel_first = 0;
        n_pulses  = 0;
        rel_done  = 0;
        n_err     = 0;
        for (int k = 0; k < EQ_LEN; k++) exp_q.push_back(ram_model[k]);
        i_cmd_load = 1'b1;
        tick();
        i_cmd_load = 1'b0;
        for (int rel = 1; rel <= 40 && rel_done == 0; rel++) begin
            i_cmd_teach = (rel == inj_teach_rel);
            i_wr_en     = (rel == inj_wr_rel);
            i_wr_addr   = AW'(3);
            i_wr_data   = 24'hABCDE;
            tick();
            i_cmd_teach = 1'b0;
            i_wr_en     = 1'b0;
            if (o_err) n_err++;
            if (o_load_coe) begin
                n_pulses++;
                if (rel_first == 0) rel_first = rel;
                if (exp_q.size() == 0) begin
                    chk("sb_extra_pulse", 32'(exp_q.size()), 32'd1);
                end else begin
                    exp_v = exp_q.pop_front();
                    chk("init_coe", 32'(o_init_coe), 32'(exp_v));
                end
                if (rst_pulse != 0 && n_pulses == rst_pulse) begin
                    reset_n = 1'b0;
                    #1;
                    chk("rst_load_coe", 32'(o_load_coe), 32'd0);
                    chk("rst_init_coe", 32'(o_init_coe), 32'd0);
                    chk("rst_busy", 32'(o_busy), 32'd0);
                    return;
                end
            end
            if (o_done) begin
                rel_done = rel;
                chk("done_busy", 32'(o_busy), 32'd0);
                chk("done_load_coe", 32'(o_load_coe), 32'd0);
            end
        end
    endtask

    initial begin
        int nsym;
        reset_n      = 1'b0;
        i_wr_en      = 1'b0;
        i_wr_addr    = '0;
        i_wr_data    = '0;
        i_cmd_preset = 1'b0;
        i_cmd_load   = 1'b0;
        i_cmd_teach  = 1'b0;
        i_cmd_stop   = 1'b0;
        i_norm_per   = '0;
        i_sym_vld    = 1'b0;
        i_train_len  = '0;
        repeat (3) @(posedge clk);
        #1;

        // reset state
        chk("rst_busy0", 32'(o_busy), 32'd0);
        chk("rst_load0", 32'(o_load_coe), 32'd0);
        chk("rst_init0", 32'(o_init_coe), 32'd0);
        chk("rst_teach0", 32'(o_teach_en), 32'd0);
        chk("rst_norm0", 32'(o_norm_per), 32'd0);
        chk("rst_preset0", 32'(o_preset_coe), 32'd0);
        chk("rst_done0", 32'(o_done), 32'd0);
        chk("rst_err0", 32'(o_err), 32'd0);
        reset_n = 1'b1;
        tick();

        // 1: fill RAM with k+1 and burst it out
        for (int k = 0; k < EQ_LEN; k++) wr(k, 24'(k + 1));
        chk("wr_ok_err", 32'(o_err), 32'd0);
        run_load(0, 0, 0);
        chk("t1_first", 32'(rel_first), 32'd1);
        chk("t1_pulses", 32'(n_pulses), 32'd17);
        chk("t1_done", 32'(rel_done), 32'd18);
        chk("t1_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("t1_err", 32'(n_err), 32'd0);
        tick();
        chk("t1_done_pulse", 32'(o_done), 32'd0);

        // 2: preset is a single cycle, then done
        i_cmd_preset = 1'b1;
        tick();
        i_cmd_preset = 1'b0;
        chk("t2_preset", 32'(o_preset_coe), 32'd1);
        chk("t2_busy", 32'(o_busy), 32'd1);
        chk("t2_nodone", 32'(o_done), 32'd0);
        tick();
        chk("t2_preset_off", 32'(o_preset_coe), 32'd0);
        chk("t2_done", 32'(o_done), 32'd1);
        chk("t2_idle", 32'(o_busy), 32'd0);
        tick();
        chk("t2_done_off", 32'(o_done), 32'd0);

        // priority: preset wins over simultaneous load and teach
        i_cmd_preset = 1'b1;
        i_cmd_load   = 1'b1;
        i_cmd_teach  = 1'b1;
        tick();
        i_cmd_preset = 1'b0;
        i_cmd_load   = 1'b0;
        i_cmd_teach  = 1'b0;
        chk("prio_preset", 32'(o_preset_coe), 32'd1);
        chk("prio_noerr", 32'(o_err), 32'd0);
        tick();
        chk("prio_done", 32'(o_done), 32'd1);
        tick();
        chk("prio_no_load", 32'(o_load_coe), 32'd0);
        chk("prio_no_teach", 32'(o_teach_en), 32'd0);
        chk("prio_idle", 32'(o_busy), 32'd0);

        // stop while in PRESET is rejected; stop in IDLE is silent
        i_cmd_preset = 1'b1;
        tick();
        i_cmd_preset = 1'b0;
        i_cmd_stop   = 1'b1;
        tick();
        i_cmd_stop   = 1'b0;
        chk("stop_preset_err", 32'(o_err), 32'd1);
        chk("stop_preset_done", 32'(o_done), 32'd1);
        i_cmd_stop = 1'b1;
        tick();
        i_cmd_stop = 1'b0;
        chk("stop_idle_err", 32'(o_err), 32'd0);
        chk("stop_idle_busy", 32'(o_busy), 32'd0);

        // 3: training window, norm period frozen
`ifdef PCMA_EQ_TRAIN_TIMER_EN
        i_train_len = '0;
`else
        i_train_len = 24'd3;
`endif
        i_norm_per  = 10'd100;
        i_cmd_teach = 1'b1;
        tick();
        i_cmd_teach = 1'b0;
        i_norm_per  = 10'd5;
        chk("t3_teach_en", 32'(o_teach_en), 32'd1);
        chk("t3_norm", 32'(o_norm_per), 32'd100);
        chk("t3_busy", 32'(o_busy), 32'd1);
        i_sym_vld = 1'b1;
        repeat (8) tick();
        i_sym_vld = 1'b0;
        chk("t3_no_timeout", 32'(o_teach_en), 32'd1);
        wr(5, 24'h777);
        chk("t3_wr_ok", 32'(o_err), 32'd0);
        i_cmd_load = 1'b1;
        tick();
        i_cmd_load = 1'b0;
        chk("t3_load_rej", 32'(o_err), 32'd1);
        chk("t3_still_teach", 32'(o_teach_en), 32'd1);
        chk("t3_no_burst", 32'(o_load_coe), 32'd0);
        chk("t3_norm_frozen", 32'(o_norm_per), 32'd100);
        i_cmd_stop = 1'b1;
        chk("t3_teach_before_stop", 32'(o_teach_en), 32'd1);
        tick();
        i_cmd_stop = 1'b0;
        chk("t3_teach_off", 32'(o_teach_en), 32'd0);
        chk("t3_done", 32'(o_done), 32'd1);
        chk("t3_idle", 32'(o_busy), 32'd0);

        // write and load in the same IDLE cycle: burst carries the new value
        i_wr_en      = 1'b1;
        i_wr_addr    = AW'(0);
        i_wr_data    = 24'h55;
        ram_model[0] = 24'h55;
        run_load(0, 0, 0);
        chk("wl_pulses", 32'(n_pulses), 32'd17);
        chk("wl_sb_empty", 32'(exp_q.size()), 32'd0);
        tick();

        // out-of-range write is rejected; last valid tap accepted
        i_wr_en   = 1'b1;
        i_wr_addr = AW'(17);
        i_wr_data = 24'hBAD;
        tick();
        i_wr_en   = 1'b0;
        chk("wr_oob_err", 32'(o_err), 32'd1);
        wr(16, 24'h1616);
        chk("wr_last_ok", 32'(o_err), 32'd0);

        // 4: command and write during LOAD are rejected, burst intact
        run_load(3, 6, 0);
        chk("t4_errs", 32'(n_err), 32'd2);
        chk("t4_pulses", 32'(n_pulses), 32'd17);
        chk("t4_done", 32'(rel_done), 32'd18);
        tick();
        chk("t4_no_teach", 32'(o_teach_en), 32'd0);
        run_load(0, 0, 0);
        chk("t4_ram_same", 32'(n_pulses), 32'd17);
        chk("t4_sb_empty", 32'(exp_q.size()), 32'd0);
        tick();

        // 5: reset at the 5th pulse, then RAM must still hold its contents
        run_load(0, 0, 5);
        chk("t5_cut_pulses", 32'(n_pulses), 32'd5);
        exp_q.delete();
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        chk("t5_idle", 32'(o_busy), 32'd0);
        chk("t5_load_off", 32'(o_load_coe), 32'd0);
        run_load(0, 0, 0);
        chk("t5_pulses", 32'(n_pulses), 32'd17);
        chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);
        tick();

`ifdef PCMA_EQ_TRAIN_TIMER_EN
        // 6: automatic end after 50 symbols, symbol every 2nd cycle
        i_train_len = 24'd50;
        i_cmd_teach = 1'b1;
        tick();
        i_cmd_teach = 1'b0;
        nsym = 0;
        rel_done = 0;
        for (int i = 0; i < 300; i++) begin
            i_sym_vld = (i % 2 == 0);
            if (o_teach_en && i_sym_vld) nsym++;
            tick();
            if (o_done) begin
                rel_done = 1;
                break;
            end
        end
        i_sym_vld = 1'b0;
        chk("t6_done_seen", 32'(rel_done), 32'd1);
        chk("t6_symbols", 32'(nsym), 32'd50);
        chk("t6_teach_off", 32'(o_teach_en), 32'd0);
`else
        nsym = 0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
